cond_unit: RTL and testbench

- Execute-stage conditional-execution unit for the ARMv4 processor.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the stored flags.
- Gates the PC, register-file and memory write strobes. Updates flags from the ALU result.
- Keeps saturating counters of executed and squashed instructions, plus a sticky undefined-condition error bit.

---
 rtl/cond_unit.sv | 88 ++++++++
 tb/tb_cond_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// cond_unit: ARMv4 execute-stage condition check, write-strobe gating,
// NZCV flag register, saturating executed/squashed counters and sticky Undef.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             ClrCnt,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount,
  output logic             Undef
);
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_exec;
  logic [CNT_W-1:0] r_squash;
  logic             r_undef;
  logic             w_n, w_z, w_c, w_v, w_pass, w_go, w_issue;
  assign {w_n, w_z, w_c, w_v} = r_flags;
  // Evaluated on the stored flags so a flag-setting instruction only affects its successors.
  always_comb begin
    w_pass = 1'b0;
    case (Cond)
      4'b0000: w_pass = w_z;
      4'b0001: w_pass = ~w_z;
      4'b0010: w_pass = w_c;
      4'b0011: w_pass = ~w_c;
      4'b0100: w_pass = w_n;
      4'b0101: w_pass = ~w_n;
      4'b0110: w_pass = w_v;
      4'b0111: w_pass = ~w_v;
      4'b1000: w_pass = w_c & ~w_z;
      4'b1001: w_pass = ~(w_c & ~w_z);
      4'b1010: w_pass = w_n == w_v;
      4'b1011: w_pass = w_n != w_v;
      4'b1100: w_pass = ~w_z & (w_n == w_v);
      4'b1101: w_pass = ~(~w_z & (w_n == w_v));
      4'b1110: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end
  assign CondEx   = Valid & w_pass;
  assign w_go     = CondEx & ~Stall;
  assign w_issue  = Valid & ~Stall;
  assign PCSrc    = PCS & w_go;
  assign RegWrite = RegW & ~NoWrite & w_go;
  assign MemWrite = MemW & w_go;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_go) begin
      if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exec   <= '0;
      r_squash <= '0;
      r_undef  <= 1'b0;
    end else if (ClrCnt) begin
      r_exec   <= '0;
      r_squash <= '0;
      r_undef  <= 1'b0;
    end else if (w_issue) begin
      if (CondEx && !(&r_exec)) r_exec <= r_exec + CNT_W'(1);
      if (!CondEx && !(&r_squash)) r_squash <= r_squash + CNT_W'(1);
      if (Cond == 4'b1111) r_undef <= 1'b1;
    end
  end
  assign Flags       = r_flags;
  assign ExecCount   = r_exec;
  assign SquashCount = r_squash;
  assign Undef       = r_undef;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed literal checks plus randomized traffic compared every
// cycle against a behavioural model of the condition unit (CNT_W=4).
module tb_cond_unit;
  localparam int W = 4;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 0, reset = 1;
  logic Valid = 0, Stall = 0, PCS = 0, RegW = 0, MemW = 0, NoWrite = 0, ClrCnt = 0;
  logic [3:0] Cond = 0, ALUFlags = 0;
  logic [1:0] FlagW = 0;
  logic [3:0] Flags;
  logic CondEx, PCSrc, RegWrite, MemWrite, Undef;
  logic [W-1:0] ExecCount, SquashCount;
  int total = 0, bad = 0;
  int m_flags = 0, m_exec = 0, m_squash = 0, m_undef = 0;

  cond_unit #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .ClrCnt(ClrCnt), .Flags(Flags), .CondEx(CondEx),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ExecCount(ExecCount), .SquashCount(SquashCount), .Undef(Undef)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Odd conditions are the complement of the preceding even one; 14/15 are fixed.
  function automatic int pass(input int c, input int f);
    int n, z, cc, v, b;
    n = (f >> 3) & 1; z = (f >> 2) & 1; cc = (f >> 1) & 1; v = f & 1;
    if (c == 14) return 1;
    if (c == 15) return 0;
    case (c / 2)
      0: b = z;
      1: b = cc;
      2: b = n;
      3: b = v;
      4: b = (cc == 1 && z == 0) ? 1 : 0;
      5: b = (n == v) ? 1 : 0;
      default: b = (z == 0 && n == v) ? 1 : 0;
    endcase
    return (c % 2 == 1) ? 1 - b : b;
  endfunction

  function automatic int exp_condex();
    return Valid ? pass(int'(Cond), m_flags) : 0;
  endfunction

  always @(posedge clk) begin
    int ex, f;
    if (reset) begin
      m_flags <= 0; m_exec <= 0; m_squash <= 0; m_undef <= 0;
    end else begin
      ex = exp_condex();
      f = m_flags;
      if (ex == 1 && !Stall) begin
        if (FlagW[1]) f = (f & 3) | (int'(ALUFlags) & 12);
        if (FlagW[0]) f = (f & 12) | (int'(ALUFlags) & 3);
      end
      m_flags <= f;
      if (ClrCnt) begin
        m_exec <= 0; m_squash <= 0; m_undef <= 0;
      end else if (Valid && !Stall) begin
        if (ex == 1) m_exec <= (m_exec < MAXC) ? m_exec + 1 : MAXC;
        else m_squash <= (m_squash < MAXC) ? m_squash + 1 : MAXC;
        if (Cond == 4'hF) m_undef <= 1;
      end
    end
  end

  always @(negedge clk) begin
    int ex, go;
    if (!reset) begin
      ex = exp_condex();
      go = (ex == 1 && !Stall) ? 1 : 0;
      chk("flags", Flags, m_flags);
      chk("condex", CondEx, ex);
      chk("pcsrc", PCSrc, (PCS && go == 1) ? 1 : 0);
      chk("regwrite", RegWrite, (RegW && !NoWrite && go == 1) ? 1 : 0);
      chk("memwrite", MemWrite, (MemW && go == 1) ? 1 : 0);
      chk("exec", ExecCount, m_exec);
      chk("squash", SquashCount, m_squash);
      chk("undef", Undef, m_undef);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                     input logic pcs, input logic rw, input logic mw, input logic nw);
    Valid = v; Stall = 0; Cond = c; ALUFlags = a; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; ClrCnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] fs;
    logic [W-1:0] es, ss;
    #12;
    chk("rst_flags", Flags, 0);
    chk("rst_exec", ExecCount, 0);
    chk("rst_undef", Undef, 0);
    reset = 0;
    step();
    drv(1, 4'h0, 0, 0, 0, 0, 0, 0); #2 chk("eq_fail", CondEx, 0);
    step(); chk("squash1", SquashCount, 1);
    drv(1, 4'hE, 0, 0, 0, 0, 0, 0); #2 chk("al_pass", CondEx, 1);
    step(); chk("exec1", ExecCount, 1);
    drv(1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1); #2 chk("cmp_nowrite", RegWrite, 0);
    step(); chk("cmp_flags", Flags, 4'b0100);
    drv(1, 4'h0, 0, 0, 1, 0, 0, 0); #2 chk("beq_pcsrc", PCSrc, 1);
    step();
    drv(1, 4'hE, 4'b0011, 2'b11, 0, 0, 0, 0);
    step(); chk("flags_0011", Flags, 4'b0011);
    drv(1, 4'hE, 4'b1100, 2'b10, 0, 0, 0, 0);
    step(); chk("partial_flags", Flags, 4'b1111);
    drv(1, 4'hA, 0, 0, 0, 0, 0, 0); #2 chk("ge_pass", CondEx, 1);
    step();
    drv(1, 4'hC, 0, 0, 0, 0, 0, 0); #2 chk("gt_fail", CondEx, 0);
    step();
    drv(1, 4'hE, 4'b0101, 2'b11, 0, 0, 0, 0);
    step();
    fs = Flags; es = ExecCount; ss = SquashCount;
    chk("pre_stall_flags", fs, 4'b0101);
    drv(1, 4'hE, 4'b1111, 2'b11, 0, 0, 1, 0); Stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_memw", MemWrite, 0);
      step();
    end
    chk("stall_flags", Flags, fs);
    chk("stall_exec", ExecCount, es);
    chk("stall_squash", SquashCount, ss);
    drv(1, 4'hE, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_exec", ExecCount, 15);
    ClrCnt = 1;
    step(); chk("clr_exec", ExecCount, 0);
    drv(1, 4'hF, 0, 0, 0, 0, 0, 0); #2 chk("nv_condex", CondEx, 0);
    step();
    chk("undef_set", Undef, 1);
    chk("undef_squash", SquashCount, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    #1 chk("async_undef", Undef, 0);
    chk("async_flags", Flags, 0);
    step(); reset = 0;
    for (int i = 0; i < 3000; i++) begin
      Valid = ($urandom_range(0, 7) != 0);
      Stall = ($urandom_range(0, 5) == 0);
      Cond = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW = 2'($urandom_range(0, 3));
      PCS = 1'($urandom_range(0, 1));
      RegW = 1'($urandom_range(0, 1));
      MemW = 1'($urandom_range(0, 1));
      NoWrite = 1'($urandom_range(0, 1));
      ClrCnt = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 300) == 0) begin
        #2 reset = 1;
        step(); reset = 0;
      end else step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
